find_best_q: RTL
================

# find_best_q

Parametrised successor to the single-channel best-Q finder. It arms on `en`, and on `start` it reads a neighbour count and then streams that many Q values from shared memory, one read per cycle. It selects the minimum or maximum Q and its index, looks up the HCM weight selected by battery status, and outputs the weighted result in fixed point. It sits between the routing-table memory and the cluster-head decision logic, and supports pipelined memory latency, saturation and an empty-table flag.

## Interface
- `WORD_WIDTH`, 16, data/Q/HCM/battery width
- `ADDR_WIDTH`, 16, byte address width
- `NC_ADDR`, 16'h068A, neighbour-count word address
- `Q_BASE`, 16'h01C8, Q table base; word stride 2
- `HCM_BASE`, 16'h0648, HCM table base; word stride 2
- `HCM_LENGTH`, 11, HCM entries (≥2)
- `MAX_NEIGHBORS`, 32, count clamp
- `FRAC_Q`, 5, fractional bits of Q and HCM
- `FRAC_BATT`, 15, fractional bits of battery
- `MEM_LAT`, 1, read latency in cycles (1..4)

Ports:
- `clock`  in  1  rising-edge clock
- `nrst`  in  1  reset, synchronous, active-low
- `en`  in  1  arm request; clears `done`
- `start`  in  1  begin search (honoured only when ARMED)
- `find_max`  in  1  1 = maximum search, 0 = minimum; latched at start
- `battery`  in  WORD_WIDTH  unsigned battery status; latched at start
- `data_in`  in  WORD_WIDTH  memory read data
- `addr`  out  ADDR_WIDTH  registered read address
- `rd_en`  out  1  registered read strobe
- `best`  out  WORD_WIDTH  weighted best Q
- `best_idx`  out  WORD_WIDTH  neighbour index of best Q
- `best_valid`  out  1  0 when neighbour count was 0
- `done`  out  1  result valid, held until `en`
- `busy`  out  1  high from the cycle after start through the cycle before done

## Operation
- States: DISARMED → ARMED → READ_NC → SCAN → HCM_READ → MULT → DISARMED.
- Reset state is DISARMED.
- DISARMED + `en` → ARMED; clears `done`, `best_valid`, `best_idx`; sets `best` to the initial value.
  - Initial value is all-ones for min mode and 0 for max mode, chosen from `find_max` at arming.
  - Re-latched at start.
- ARMED + `start` → READ_NC. `start` is ignored in all other states. `en` is ignored outside DISARMED.
- Neighbour count N = min(`data_in`, `MAX_NEIGHBORS`).
  - N = 0: skip SCAN and HCM_READ; `best` = initial value, `best_valid` = 0, `best_idx` = 0, done.
- SCAN:
  - Issues Q[i] at `Q_BASE`+2i, one per cycle, i = 0..N-1.
  - Compares each returned value with a strict compare (< for min, > for max); ties keep the earliest index.
- HCM index:
  - k = ceil((HCM_LENGTH-1)·battery / 2^FRAC_BATT), clamped to HCM_LENGTH-1.
  - Computed from the latched battery during SCAN.
  - The HCM read at `HCM_BASE`+2k issues the cycle after the last Q read.
- MULT:
  - `best` = (best_raw · hcm) >> FRAC_Q, with a full 2·WORD_WIDTH product.
  - Saturates to all-ones if the shifted result exceeds WORD_WIDTH.
  - `best_valid` = 1.
- Reset mid-operation: abort immediately to DISARMED with all outputs at reset values. No further reads.

## Timing
- Reset values: `addr` = NC_ADDR, `rd_en` = 0, `best` = all-ones, `best_idx` = 0, `best_valid` = 0, `done` = 0, `busy` = 0.
- Memory contract: data for the address driven in cycle c is valid on `data_in` in cycle c+L (L = MEM_LAT).
- `rd_en` is high only in issue cycles.
- Cycle 0: `start` sampled. Cycle 1: NC read issued. Cycle 1+L: count captured.
- Q[i] is issued in cycle 2+L+i and captured in cycle 2+2L+i.
- HCM read is issued in cycle 2+L+N and captured in cycle 2+2L+N (MULT).
- `done` and the final outputs are valid from cycle 3+2L+N; for N = 0, from cycle 2+L.
- `done` stays high in DISARMED until the cycle after `en` is sampled.
- Outputs hold their values until the next arm.

## Test plan
- L=1, min, N=3, Q={0x0040,0x0020,0x0060}, battery=0x4000, HCM[5]=0x0040 → k=5, `best`=0x0040, `best_idx`=1, `done` at cycle 8.
- Same data, `find_max`=1 → `best`=0x00C0, `best_idx`=2.
- N=0 → no Q or HCM reads, `best`=0xFFFF, `best_valid`=0, `done` at cycle 3.
- Battery sweep:
  - 0x0000 → k=0
  - 0x7FFF → k=10
  - 0xFFFF → raw ceiling 20, clamped to k=10
  - Check each via the HCM read address.
- Q={0xFFF0}, HCM=0x0100 → saturated `best`=0xFFFF. Ties with Q={0x10,0x10} → `best_idx`=0.
- Count=40 with `MAX_NEIGHBORS`=32 → exactly 32 Q reads.
- `nrst` low mid-SCAN → next cycle all outputs at reset values and `rd_en`=0.
- `start` while DISARMED is ignored.

Source files
------------

// File: rtl/find_best_q.sv
// Best-Q finder: streams a neighbour count and Q table from memory, picks the min/max
// Q and its index, then weights it by a battery-selected HCM entry in fixed point.
module find_best_q #(
    parameter int unsigned WORD_WIDTH    = 16,
    parameter int unsigned ADDR_WIDTH    = 16,
    parameter int unsigned NC_ADDR       = 16'h068A,
    parameter int unsigned Q_BASE        = 16'h01C8,
    parameter int unsigned HCM_BASE      = 16'h0648,
    parameter int unsigned HCM_LENGTH    = 11,
    parameter int unsigned MAX_NEIGHBORS = 32,
    parameter int unsigned FRAC_Q        = 5,
    parameter int unsigned FRAC_BATT     = 15,
    parameter int unsigned MEM_LAT       = 1
) (
    input  logic                  clock,
    input  logic                  nrst,
    input  logic                  en,
    input  logic                  start,
    input  logic                  find_max,
    input  logic [WORD_WIDTH-1:0] battery,
    input  logic [WORD_WIDTH-1:0] data_in,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  rd_en,
    output logic [WORD_WIDTH-1:0] best,
    output logic [WORD_WIDTH-1:0] best_idx,
    output logic                  best_valid,
    output logic                  done,
    output logic                  busy
);

    localparam int unsigned CW = WORD_WIDTH + 2;
    localparam int unsigned KW = WORD_WIDTH + $clog2(HCM_LENGTH) + 1;
    localparam int unsigned PW = 2 * WORD_WIDTH;

    typedef enum logic [2:0] {
        ST_DISARMED,
        ST_ARMED,
        ST_READ_NC,
        ST_SCAN,
        ST_HCM_READ,
        ST_MULT
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  rd_en_q, rd_en_d;
    logic [WORD_WIDTH-1:0] best_q, best_d;
    logic [WORD_WIDTH-1:0] idx_q, idx_d;
    logic                  valid_q, valid_d;
    logic                  done_q, done_d;
    logic                  mode_q, mode_d;
    logic [WORD_WIDTH-1:0] batt_q, batt_d;
    logic [CW-1:0]         n_q, n_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [WORD_WIDTH-1:0] raw_q, raw_d;
    logic [WORD_WIDTH-1:0] raw_idx_q, raw_idx_d;

    logic [CW-1:0]         t1;
    logic [CW-1:0]         cap_j;
    logic                  cap_ok;
    logic                  q_better;
    logic [CW-1:0]         nc_clamped;
    logic [KW-1:0]         k_prod;
    logic [KW-1:0]         k_ceil;
    logic [ADDR_WIDTH-1:0] k_sel;
    logic [ADDR_WIDTH-1:0] q_addr;
    logic [ADDR_WIDTH-1:0] hcm_addr;
    logic [PW-1:0]         prod;
    logic [PW-1:0]         prod_shift;
    logic [WORD_WIDTH-1:0] weighted;

    always_comb begin
        t1         = cnt_q + CW'(1);
        // Data returning now was issued MEM_LAT cycles ago, so it belongs to Q[cnt - MEM_LAT].
        cap_j      = cnt_q - CW'(MEM_LAT);
        cap_ok     = (cnt_q >= CW'(MEM_LAT)) && (cap_j < n_q);
        q_better   = mode_q ? (data_in > raw_q) : (data_in < raw_q);
        nc_clamped = (CW'(data_in) > CW'(MAX_NEIGHBORS)) ? CW'(MAX_NEIGHBORS) : CW'(data_in);

        k_prod     = KW'(HCM_LENGTH - 1) * KW'(batt_q);
        k_ceil     = (k_prod + ((KW'(1) << FRAC_BATT) - KW'(1))) >> FRAC_BATT;
        k_sel      = (k_ceil > KW'(HCM_LENGTH - 1)) ? ADDR_WIDTH'(HCM_LENGTH - 1)
                                                    : ADDR_WIDTH'(k_ceil);
        hcm_addr   = ADDR_WIDTH'(HCM_BASE) + (k_sel << 1);
        q_addr     = ADDR_WIDTH'(Q_BASE) + (ADDR_WIDTH'(t1) << 1);

        prod       = PW'(raw_q) * PW'(data_in);
        prod_shift = prod >> FRAC_Q;
        weighted   = (|prod_shift[PW-1:WORD_WIDTH]) ? '1 : prod_shift[WORD_WIDTH-1:0];
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        rd_en_d   = 1'b0;
        best_d    = best_q;
        idx_d     = idx_q;
        valid_d   = valid_q;
        done_d    = done_q;
        mode_d    = mode_q;
        batt_d    = batt_q;
        n_d       = n_q;
        cnt_d     = cnt_q;
        raw_d     = raw_q;
        raw_idx_d = raw_idx_q;

        case (state_q)
            ST_DISARMED: begin
                if (en) begin
                    state_d = ST_ARMED;
                    done_d  = 1'b0;
                    valid_d = 1'b0;
                    idx_d   = '0;
                    best_d  = find_max ? '0 : '1;
                end
            end
            ST_ARMED: begin
                if (start) begin
                    state_d   = ST_READ_NC;
                    mode_d    = find_max;
                    batt_d    = battery;
                    best_d    = find_max ? '0 : '1;
                    raw_d     = find_max ? '0 : '1;
                    raw_idx_d = '0;
                    cnt_d     = '0;
                    addr_d    = ADDR_WIDTH'(NC_ADDR);
                    rd_en_d   = 1'b1;
                end
            end
            ST_READ_NC: begin
                if (cnt_q == CW'(MEM_LAT)) begin
                    n_d = nc_clamped;
                    if (nc_clamped == '0) begin
                        state_d = ST_DISARMED;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_SCAN;
                        cnt_d   = '0;
                        addr_d  = ADDR_WIDTH'(Q_BASE);
                        rd_en_d = 1'b1;
                    end
                end else begin
                    cnt_d = t1;
                end
            end
            ST_SCAN, ST_HCM_READ: begin
                if (cap_ok && q_better) begin
                    raw_d     = data_in;
                    raw_idx_d = WORD_WIDTH'(cap_j);
                end
                cnt_d = t1;
                if (t1 < n_q) begin
                    addr_d  = q_addr;
                    rd_en_d = 1'b1;
                end else if (t1 == n_q) begin
                    addr_d  = hcm_addr;
                    rd_en_d = 1'b1;
                    state_d = ST_HCM_READ;
                end else if (t1 == n_q + CW'(MEM_LAT)) begin
                    state_d = ST_MULT;
                end
            end
            ST_MULT: begin
                best_d  = weighted;
                idx_d   = raw_idx_q;
                valid_d = 1'b1;
                done_d  = 1'b1;
                state_d = ST_DISARMED;
            end
            default: state_d = ST_DISARMED;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!nrst) begin
            state_q   <= ST_DISARMED;
            addr_q    <= ADDR_WIDTH'(NC_ADDR);
            rd_en_q   <= 1'b0;
            best_q    <= '1;
            idx_q     <= '0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
            mode_q    <= 1'b0;
            batt_q    <= '0;
            n_q       <= '0;
            cnt_q     <= '0;
            raw_q     <= '1;
            raw_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            rd_en_q   <= rd_en_d;
            best_q    <= best_d;
            idx_q     <= idx_d;
            valid_q   <= valid_d;
            done_q    <= done_d;
            mode_q    <= mode_d;
            batt_q    <= batt_d;
            n_q       <= n_d;
            cnt_q     <= cnt_d;
            raw_q     <= raw_d;
            raw_idx_q <= raw_idx_d;
        end
    end

    always_comb begin
        addr       = addr_q;
        rd_en      = rd_en_q;
        best       = best_q;
        best_idx   = idx_q;
        best_valid = valid_q;
        done       = done_q;
        busy       = (state_q == ST_READ_NC) || (state_q == ST_SCAN) ||
                     (state_q == ST_HCM_READ) || (state_q == ST_MULT);
    end

endmodule
